// File: rtl/pokey_poly_pkg.sv
// Shared widths, tap positions and preset values for the POKEY polynomial counters.
// Long-poly next-state helper lives here so top and any future user agree on it.
package pokey_poly_pkg;

  localparam int unsigned POLY4_W  = 4;
  localparam int unsigned POLY5_W  = 5;
  localparam int unsigned POLY9_W  = 9;
  localparam int unsigned POLY17_W = 17;

  localparam int unsigned POLY4_TAP  = 1;
  localparam int unsigned POLY5_TAP  = 2;
  localparam int unsigned POLY9_TAP  = 4;
  localparam int unsigned POLY17_TAP = 5;

  localparam logic [POLY4_W-1:0]  POLY4_PRESET  = 4'hF;
  localparam logic [POLY5_W-1:0]  POLY5_PRESET  = 5'h1F;
  localparam logic [POLY17_W-1:0] POLY17_PRESET = 17'h1FFFF;

  // In 9-bit mode the upper eight bits are frozen and feedback enters bit 8.
  function automatic logic [POLY17_W-1:0] long_poly_next(input logic [POLY17_W-1:0] q,
                                                         input logic nine_bit);
    logic [POLY17_W-1:0] n;
    if (nine_bit) begin
      n = {q[POLY17_W-1:POLY9_W], q[0] ^ q[POLY9_TAP], q[POLY9_W-1:1]};
    end else begin
      n = {q[0] ^ q[POLY17_TAP], q[POLY17_W-1:1]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pokey_lfsr.sv
// Fixed-length right-shifting LFSR with two-tap XOR feedback into the MSB.
// Preset (load all-ones) dominates shift; state only changes when one of them is high.
module pokey_lfsr
  import pokey_poly_pkg::*;
#(
  parameter int unsigned WIDTH = POLY4_W,
  parameter int unsigned TAP   = POLY4_TAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic             preset_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (preset_i) begin
      q_d = '1;
    end else if (shift_en_i) begin
      q_d = {q_q[0] ^ q_q[TAP], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pokey_poly_gen.sv
// POKEY poly4/poly5/poly9-17 noise generators plus the RANDOM capture register.
// RANDOM capture exists only when POKEY_POLY_RANDOM_EN is defined; otherwise random reads 8'h00.
module pokey_poly_gen
  import pokey_poly_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enp,
  input  logic       init,
  input  logic       poly9_sel,
  input  logic       rnd_rd,
  output logic       poly4_out,
  output logic       poly5_out,
  output logic       poly17_out,
  output logic [7:0] random
);

  logic [POLY4_W-1:0]  q4;
  logic [POLY5_W-1:0]  q5;
  logic [POLY17_W-1:0] q17_q;
  logic [POLY17_W-1:0] q17_d;
  logic                preset;

  // init is only honoured on an enp edge, matching the 1.79 MHz phase.
  assign preset = enp & init;

  pokey_lfsr #(.WIDTH(POLY4_W), .TAP(POLY4_TAP)) u_poly4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (enp),
    .preset_i   (preset),
    .q_o        (q4)
  );

  pokey_lfsr #(.WIDTH(POLY5_W), .TAP(POLY5_TAP)) u_poly5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (enp),
    .preset_i   (preset),
    .q_o        (q5)
  );

  always_comb begin
    q17_d = q17_q;
    if (preset) begin
      q17_d = POLY17_PRESET;
    end else if (enp) begin
      q17_d = long_poly_next(q17_q, poly9_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q17_q <= POLY17_PRESET;
    end else begin
      q17_q <= q17_d;
    end
  end

  assign poly4_out  = q4[0];
  assign poly5_out  = q5[0];
  assign poly17_out = q17_q[0];

`ifdef POKEY_POLY_RANDOM_EN
  logic [7:0] random_q;
  logic [7:0] random_d;

  // Sampled from pre-shift contents, so a coincident enp does not affect the read.
  always_comb begin
    random_d = random_q;
    if (rnd_rd) begin
      if (init) begin
        random_d = 8'h00;
      end else if (poly9_sel) begin
        random_d = ~q17_q[8:1];
      end else begin
        random_d = ~q17_q[16:9];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_q <= 8'h00;
    end else begin
      random_q <= random_d;
    end
  end

  assign random = random_q;
`else
  logic unused_rnd_rd;
  assign unused_rnd_rd = rnd_rd;
  assign random        = 8'h00;
`endif

endmodule

// File: tb/tb_pokey_poly_gen.sv
// Scoreboarded bench for pokey_poly_gen: driver pushes expected outputs per clock,
// a negedge monitor pops and compares; directed state checks cover periods and presets.
module tb_pokey_poly_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enp = 1'b0;
  logic       init = 1'b0;
  logic       poly9_sel = 1'b0;
  logic       rnd_rd = 1'b0;
  logic       poly4_out;
  logic       poly5_out;
  logic       poly17_out;
  logic [7:0] random;

`ifdef POKEY_POLY_RANDOM_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  pokey_poly_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enp        (enp),
    .init       (init),
    .poly9_sel  (poly9_sel),
    .rnd_rd     (rnd_rd),
    .poly4_out  (poly4_out),
    .poly5_out  (poly5_out),
    .poly17_out (poly17_out),
    .random     (random)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;
  logic [10:0] mon_act;

  logic [3:0]  m4;
  logic [4:0]  m5;
  logic [16:0] m17;
  logic [7:0]  mr;
  logic [7:0]  hold_hi;

  // Hand-derived poly4 stream after preset, one bit per enp.
  logic p4_tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {random, poly17_out, poly5_out, poly4_out};
      check("outputs", {21'd0, mon_act}, {21'd0, mon_exp});
    end
  end

  task automatic model_preset();
    m4  = 4'hF;
    m5  = 5'h1F;
    m17 = 17'h1FFFF;
  endtask

  task automatic push_exp(input logic ovr, input logic p4bit);
    exp_q.push_back({mr, m17[0], m5[0], ovr ? p4bit : m4[0]});
  endtask

  // driver: one clock with the given inputs; enp/rnd_rd are single-clk pulses
  task automatic step(input logic e, input logic i, input logic s, input logic r,
                      input logic ovr = 1'b0, input logic p4bit = 1'b0);
    enp = e; init = i; poly9_sel = s; rnd_rd = r;
    @(posedge clk);
    if (r) mr = !RND_EN ? 8'h00 : (i ? 8'h00 : (s ? ~m17[8:1] : ~m17[16:9]));
    if (e) begin
      if (i) begin
        model_preset();
      end else begin
        m4 = {m4[0] ^ m4[1], m4[3:1]};
        m5 = {m5[0] ^ m5[2], m5[4:1]};
        if (s) m17 = {m17[16:9], m17[0] ^ m17[4], m17[8:1]};
        else   m17 = {m17[0] ^ m17[5], m17[16:1]};
      end
    end
    #1;
    enp = 1'b0; rnd_rd = 1'b0;
    push_exp(ovr, p4bit);
    @(negedge clk);
  endtask

  initial begin
    model_preset();
    mr = 8'h00;
    // reset state
    repeat (2) @(negedge clk);
    push_exp(1'b0, 1'b0);
    check("rst_q17", {15'd0, dut.q17_q}, 32'h1FFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // RANDOM read straight after reset release
    step(0, 0, 0, 1);
    check("rnd_after_rst", {24'd0, random}, 32'h00);

    // preset via init, then one full poly4 period against the hand table
    repeat (3) step(1, 1, 0, 0);
    for (int k = 0; k < 15; k++) step(1, 0, 0, 0, 1'b1, p4_tbl[k]);
    check("p4_wrap", {28'd0, dut.u_poly4.q_q}, 32'hF);
    repeat (16) step(1, 0, 0, 0);
    check("p5_wrap", {27'd0, dut.u_poly5.q_q}, 32'h1F);

    // one 17-bit shift from preset puts 0 into q17[16], so ~q17[16:9] = 8'h80
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("rnd_one_enp", {24'd0, random}, RND_EN ? 32'h80 : 32'h00);
    step(0, 1, 0, 1);
    check("rnd_in_init", {24'd0, random}, 32'h00);
    step(1, 0, 0, 1);

    // 9-bit period from preset
    step(1, 1, 1, 0);
    for (int k = 0; k < 511; k++) begin
      step(1, 0, 1, 0);
      if (k < 510) check("p9_nonzero", {31'd0, dut.q17_q[8:0] == 9'd0}, 32'd0);
    end
    check("p9_wrap", {15'd0, dut.q17_q}, 32'h1FFFF);

    // mode flip mid-run: no reload, upper byte frozen from next enp on
    step(1, 1, 0, 0);
    repeat (50) step(1, 0, 0, 0);
    hold_hi = m17[16:9];
    step(0, 0, 1, 1);
    for (int k = 0; k < 50; k++) begin
      step(1, 0, 1, (k % 7) == 3);
      check("p9_frozen", {24'd0, dut.q17_q[16:9]}, {24'd0, hold_hi});
    end

    // long 17-bit run, coincident reads, never all-zeros
    for (int k = 0; k < 2000; k++) begin
      step(1, 0, 0, (k % 97) == 5);
      check("p17_nonzero", {31'd0, dut.q17_q == 17'd0}, 32'd0);
    end

    // init without enp holds state; init with enp presets
    repeat (5) step(0, 1, 0, 0);
    check("init_no_enp", {15'd0, dut.q17_q}, {15'd0, m17});
    step(1, 1, 0, 0);
    check("init_preset", {15'd0, dut.q17_q}, 32'h1FFFF);
    repeat (20) step(1, 0, 0, 0);
    step(0, 0, 0, 1);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {21'd0, random, poly17_out, poly5_out, poly4_out}, 32'h007);
    check("async_rst_q17", {15'd0, dut.q17_q}, 32'h1FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    model_preset();
    mr = 8'h00;
    repeat (4) step(1, 0, 0, 0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
